mips_encode: RTL and testbench

//  Inverse of the MIPS control decoder. Accepts ALU-instruction requests (alu_op, operand source,

---
 rtl/mips_encode_pkg.sv | 76 +++++++
 rtl/mips_encode_if.sv | 37 +++
 rtl/mips_encode_inst_fifo.sv | 65 ++++++
 rtl/mips_encode.sv | 61 ++++++
 tb/tb_mips_encode.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_encode_pkg.sv
`default_nettype none
// ============================================================================
//  mips_encode_pkg
//  ALU/opcode/funct codes shared with the MIPS control decoder, plus the
//  combinational request-to-instruction encoder.
//  Revision: 1.0
// ============================================================================
package mips_encode_pkg;

   localparam logic [2:0] c_alu_add = 3'b010;
   localparam logic [2:0] c_alu_sub = 3'b011;
   localparam logic [2:0] c_alu_and = 3'b100;
   localparam logic [2:0] c_alu_or  = 3'b101;
   localparam logic [2:0] c_alu_nor = 3'b110;
   localparam logic [2:0] c_alu_xor = 3'b111;

   localparam logic [5:0] c_op_other0 = 6'h00;
   localparam logic [5:0] c_op_addi   = 6'h08;
   localparam logic [5:0] c_op_addiu  = 6'h09;
   localparam logic [5:0] c_op_andi   = 6'h0C;
   localparam logic [5:0] c_op_ori    = 6'h0D;
   localparam logic [5:0] c_op_xori   = 6'h0E;

   localparam logic [5:0] c_op0_add  = 6'h20;
   localparam logic [5:0] c_op0_addu = 6'h21;
   localparam logic [5:0] c_op0_sub  = 6'h22;
   localparam logic [5:0] c_op0_subu = 6'h23;
   localparam logic [5:0] c_op0_and  = 6'h24;
   localparam logic [5:0] c_op0_or   = 6'h25;
   localparam logic [5:0] c_op0_xor  = 6'h26;
   localparam logic [5:0] c_op0_nor  = 6'h27;

   typedef struct packed {
      logic        ok;
      logic [31:0] word;
   } enc_t;

   // ok=0 marks a request that has no MIPS encoding (I-type SUB/NOR, op 000/001).
   function automatic enc_t encode(input logic [2:0]  alu_op,
                                   input logic        imm,
                                   input logic        trap,
                                   input logic [4:0]  rs,
                                   input logic [4:0]  rt,
                                   input logic [4:0]  rd,
                                   input logic [15:0] imm16);
      enc_t       e;
      logic [5:0] code;
      e.ok   = 1'b1;
      e.word = 32'h0;
      code   = 6'h00;
      if (imm) begin
         case (alu_op)
            c_alu_add: code = trap ? c_op_addi : c_op_addiu;
            c_alu_and: code = c_op_andi;
            c_alu_or:  code = c_op_ori;
            c_alu_xor: code = c_op_xori;
            default:   e.ok = 1'b0;
         endcase
         if (e.ok) e.word = {code, rs, rd, imm16};
      end else begin
         case (alu_op)
            c_alu_add: code = trap ? c_op0_add : c_op0_addu;
            c_alu_sub: code = trap ? c_op0_sub : c_op0_subu;
            c_alu_and: code = c_op0_and;
            c_alu_or:  code = c_op0_or;
            c_alu_xor: code = c_op0_xor;
            c_alu_nor: code = c_op0_nor;
            default:   e.ok = 1'b0;
         endcase
         if (e.ok) e.word = {c_op_other0, rs, rt, rd, 5'b00000, code};
      end
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_encode_if.sv
`default_nettype none
// ============================================================================
//  mips_encode_if
//  Request / instruction-stream / status bundle of the MIPS encoder.
//  Revision: 1.0
// ============================================================================
interface mips_encode_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [2:0]              in_alu_op;
   logic                    in_imm;
   logic                    in_trap;
   logic [4:0]              in_rs;
   logic [4:0]              in_rt;
   logic [4:0]              in_rd;
   logic [15:0]             in_imm16;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             out_inst;
   logic                    err;
   logic [CNT_W-1:0]        err_count;
   logic [$clog2(DEPTH):0]  level;

   modport master (
      output in_valid, in_alu_op, in_imm, in_trap, in_rs, in_rt, in_rd, in_imm16, out_ready,
      input  in_ready, out_valid, out_inst, err, err_count, level
   );

   modport slave (
      input  in_valid, in_alu_op, in_imm, in_trap, in_rs, in_rt, in_rd, in_imm16, out_ready,
      output in_ready, out_valid, out_inst, err, err_count, level
   );
endinterface
`default_nettype wire

// File: rtl/mips_encode_inst_fifo.sv
`default_nettype none
// ============================================================================
//  inst_fifo
//  Synchronous FIFO with a registered head word; full/empty come from level.
//  Revision: 1.0
// ============================================================================
module inst_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  wire logic                       clk,
   input  wire logic                       rst,
   input  wire logic                       push,
   input  wire logic [WIDTH-1:0]           din,
   input  wire logic                       pop,
   output logic      [WIDTH-1:0]           dout,
   output logic      [$clog2(DEPTH):0]     level,
   output logic                            full,
   output logic                            empty
);
   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW:0]    C_FULL  = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_level;
   logic [WIDTH-1:0] r_head;

   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_rd_next;
   logic [AW:0]      w_level_next;

   assign full         = (r_level == C_FULL);
   assign empty        = (r_level == '0);
   assign w_push       = push & ~full;
   assign w_pop        = pop & ~empty;
   assign w_rd_next    = r_rd + AW'(w_pop);
   assign w_level_next = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         r_head  <= '0;
      end else begin
         r_wr    <= r_wr + AW'(w_push);
         r_rd    <= w_rd_next;
         r_level <= w_level_next;
         // The next head is the word being written now when it lands in the read slot.
         if (w_level_next != '0)
            r_head <= (w_push && (w_rd_next == r_wr)) ? din : r_mem[w_rd_next];
      end
   end

   assign dout  = r_head;
   assign level = r_level;
endmodule
`default_nettype wire

// File: rtl/mips_encode.sv
`default_nettype none
// ============================================================================
//  mips_encode
//  Encodes ALU requests into MIPS R/I-type words, buffers them, counts rejects.
//  Revision: 1.0
// ============================================================================
module mips_encode
   import mips_encode_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input wire logic     clock,
   input wire logic     reset,
   mips_encode_if.slave bus
);
   enc_t             w_enc;
   logic             w_accept;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic             r_err;
   logic [CNT_W-1:0] r_err_count;

   assign w_enc    = encode(bus.in_alu_op, bus.in_imm, bus.in_trap,
                            bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm16);
   assign w_accept = bus.in_valid & ~w_full;
   assign w_push   = w_accept & w_enc.ok;

   inst_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clock),
      .rst   (reset),
      .push  (w_push),
      .din   (w_enc.word),
      .pop   (bus.out_ready),
      .dout  (bus.out_inst),
      .level (bus.level),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_err       <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_err <= w_accept & ~w_enc.ok;
         if (w_accept && !w_enc.ok && (r_err_count != '1))
            r_err_count <= r_err_count + 1'b1;
      end
   end

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = ~w_empty;
   assign bus.err       = r_err;
   assign bus.err_count = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_mips_encode.sv
`default_nettype none
// ============================================================================
//  tb_mips_encode
//  Directed self-checking bench for mips_encode with hand-computed words.
//  Revision: 1.0
// ============================================================================
module tb_mips_encode;
   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   mips_encode_if #(.DEPTH(4), .CNT_W(8)) bus ();
   mips_encode #(.DEPTH(4), .CNT_W(8)) dut (.clock(clock), .reset(reset), .bus(bus));

   typedef struct {
      logic [2:0]  op;
      logic        imm;
      logic        trap;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] k;
      logic [31:0] exp;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic v, input logic [2:0] op, input logic imm, input logic trap,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [15:0] k);
      bus.in_valid  = v;
      bus.in_alu_op = op;
      bus.in_imm    = imm;
      bus.in_trap   = trap;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_imm16  = k;
   endtask

   task automatic test_reset();
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      bus.out_ready = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks += 6;
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.level); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
      if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", bus.err_count); end
      if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst got %h want 0", bus.out_inst); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
   endtask

   task automatic test_rtype_add();
      bus.out_ready = 1'b1;
      put(1'b1, 3'b010, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 16'hBEEF);
      tick();
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      n_checks += 3;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got %b want 1", bus.out_valid); end
      if (bus.out_inst !== 32'h00221820) begin n_fail++; $display("FAIL add_inst got %h want 00221820", bus.out_inst); end
      if (bus.level !== 3'd1) begin n_fail++; $display("FAIL add_level got %0d want 1", bus.level); end
      tick();
      n_checks += 3;
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL add_drain_level got %0d want 0", bus.level); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain_valid got %b want 0", bus.out_valid); end
      if (bus.out_inst !== 32'h00221820) begin n_fail++; $display("FAIL add_hold_inst got %h want 00221820", bus.out_inst); end
   endtask

   task automatic test_encode_table();
      vec_t tbl[12];
      tbl[0]  = '{3'b010, 1'b1, 1'b1, 5'd4,  5'd31, 5'd5, 16'hFFFF, 32'h2085FFFF};
      tbl[1]  = '{3'b010, 1'b1, 1'b0, 5'd4,  5'd31, 5'd5, 16'hFFFF, 32'h2485FFFF};
      tbl[2]  = '{3'b101, 1'b1, 1'b0, 5'd0,  5'd9,  5'd2, 16'h00FF, 32'h340200FF};
      tbl[3]  = '{3'b011, 1'b0, 1'b0, 5'd1,  5'd2,  5'd3, 16'hABCD, 32'h00221823};
      tbl[4]  = '{3'b011, 1'b0, 1'b1, 5'd1,  5'd2,  5'd3, 16'hABCD, 32'h00221822};
      tbl[5]  = '{3'b010, 1'b0, 1'b0, 5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221821};
      tbl[6]  = '{3'b100, 1'b0, 1'b1, 5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221824};
      tbl[7]  = '{3'b101, 1'b0, 1'b0, 5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221825};
      tbl[8]  = '{3'b111, 1'b0, 1'b1, 5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221826};
      tbl[9]  = '{3'b110, 1'b0, 1'b1, 5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221827};
      tbl[10] = '{3'b100, 1'b1, 1'b1, 5'd1,  5'd30, 5'd3, 16'h8000, 32'h30238000};
      tbl[11] = '{3'b111, 1'b1, 1'b0, 5'd31, 5'd7,  5'd0, 16'h1234, 32'h3BE01234};
      bus.out_ready = 1'b1;
      // Each new word is pushed while the previous head pops, so level stays at 1.
      for (int i = 0; i < 12; i++) begin
         put(1'b1, tbl[i].op, tbl[i].imm, tbl[i].trap, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].k);
         tick();
         n_checks += 3;
         if (bus.out_inst !== tbl[i].exp) begin n_fail++; $display("FAIL enc_inst[%0d] got %h want %h", i, bus.out_inst, tbl[i].exp); end
         if (bus.level !== 3'd1) begin n_fail++; $display("FAIL enc_level[%0d] got %0d want 1", i, bus.level); end
         if (bus.err !== 1'b0) begin n_fail++; $display("FAIL enc_err[%0d] got %b want 0", i, bus.err); end
      end
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      tick();
      n_checks++;
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL enc_drain_level got %0d want 0", bus.level); end
   endtask

   task automatic test_reject();
      bus.out_ready = 1'b1;
      put(1'b1, 3'b110, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 16'h5555);
      tick();
      n_checks += 4;
      if (bus.err !== 1'b1) begin n_fail++; $display("FAIL rej_nori_err got %b want 1", bus.err); end
      if (bus.err_count !== 8'd1) begin n_fail++; $display("FAIL rej_nori_count got %0d want 1", bus.err_count); end
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL rej_nori_level got %0d want 0", bus.level); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rej_nori_ready got %b want 1", bus.in_ready); end
      put(1'b1, 3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 16'h0);
      tick();
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      n_checks += 4;
      if (bus.err !== 1'b1) begin n_fail++; $display("FAIL rej_op0_err got %b want 1", bus.err); end
      if (bus.err_count !== 8'd2) begin n_fail++; $display("FAIL rej_op0_count got %0d want 2", bus.err_count); end
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL rej_op0_level got %0d want 0", bus.level); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rej_op0_valid got %b want 0", bus.out_valid); end
      tick();
      n_checks += 3;
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rej_pulse_end got %b want 0", bus.err); end
      if (bus.err_count !== 8'd2) begin n_fail++; $display("FAIL rej_count_hold got %0d want 2", bus.err_count); end
      if (bus.out_inst !== 32'h3BE01234) begin n_fail++; $display("FAIL rej_inst_hold got %h want 3be01234", bus.out_inst); end
   endtask

   task automatic test_back_to_back_full();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         put(1'b1, 3'b111, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 16'h1000 + 16'(i));
         tick();
         n_checks++;
         if (bus.level !== 3'(i + 1)) begin n_fail++; $display("FAIL full_fill_level[%0d] got %0d want %0d", i, bus.level, i + 1); end
      end
      n_checks += 2;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", bus.in_ready); end
      if (bus.out_inst !== 32'h38001000) begin n_fail++; $display("FAIL full_head got %h want 38001000", bus.out_inst); end
      put(1'b1, 3'b111, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 16'h1004);
      tick();
      n_checks += 2;
      if (bus.level !== 3'd4) begin n_fail++; $display("FAIL full_stall_level got %0d want 4", bus.level); end
      if (bus.out_inst !== 32'h38001000) begin n_fail++; $display("FAIL full_stall_head got %h want 38001000", bus.out_inst); end
      bus.out_ready = 1'b1;
      tick();
      n_checks += 3;
      if (bus.level !== 3'd3) begin n_fail++; $display("FAIL full_pop_level got %0d want 3", bus.level); end
      if (bus.out_inst !== 32'h38001001) begin n_fail++; $display("FAIL full_pop_head got %h want 38001001", bus.out_inst); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready got %b want 1", bus.in_ready); end
      tick();
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      n_checks += 2;
      if (bus.level !== 3'd3) begin n_fail++; $display("FAIL full_fifth_level got %0d want 3", bus.level); end
      if (bus.out_inst !== 32'h38001002) begin n_fail++; $display("FAIL full_fifth_head got %h want 38001002", bus.out_inst); end
      tick();
      n_checks++;
      if (bus.out_inst !== 32'h38001003) begin n_fail++; $display("FAIL full_order3 got %h want 38001003", bus.out_inst); end
      tick();
      n_checks += 2;
      if (bus.out_inst !== 32'h38001004) begin n_fail++; $display("FAIL full_order4 got %h want 38001004", bus.out_inst); end
      if (bus.level !== 3'd1) begin n_fail++; $display("FAIL full_order4_level got %0d want 1", bus.level); end
      tick();
      n_checks += 2;
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL full_empty_level got %0d want 0", bus.level); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_reset_midflight();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         put(1'b1, 3'b100, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 16'h00A0 + 16'(i));
         tick();
      end
      n_checks += 3;
      if (bus.level !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level got %0d want 3", bus.level); end
      if (bus.err_count !== 8'd2) begin n_fail++; $display("FAIL mid_pre_count got %0d want 2", bus.err_count); end
      if (bus.out_inst !== 32'h300000A0) begin n_fail++; $display("FAIL mid_pre_head got %h want 300000a0", bus.out_inst); end
      put(1'b1, 3'b100, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 16'h00EE);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      n_checks += 5;
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", bus.level); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", bus.out_valid); end
      if (bus.err_count !== 8'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", bus.err_count); end
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", bus.in_ready); end
      if (bus.out_inst !== 32'h0) begin n_fail++; $display("FAIL mid_inst got %h want 0", bus.out_inst); end
      tick();
      n_checks += 2;
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL mid_lost_level got %0d want 0", bus.level); end
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lost_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_err_saturate();
      bus.out_ready = 1'b1;
      put(1'b1, 3'b001, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h0);
      repeat (254) tick();
      n_checks++;
      if (bus.err_count !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", bus.err_count); end
      tick();
      n_checks++;
      if (bus.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", bus.err_count); end
      repeat (3) tick();
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      n_checks += 3;
      if (bus.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", bus.err_count); end
      if (bus.err !== 1'b1) begin n_fail++; $display("FAIL sat_err got %b want 1", bus.err); end
      if (bus.level !== 3'd0) begin n_fail++; $display("FAIL sat_level got %0d want 0", bus.level); end
      tick();
      n_checks += 2;
      if (bus.err !== 1'b0) begin n_fail++; $display("FAIL sat_err_end got %b want 0", bus.err); end
      if (bus.err_count !== 8'd255) begin n_fail++; $display("FAIL sat_final got %0d want 255", bus.err_count); end
   endtask

   initial begin
      reset         = 1'b1;
      bus.out_ready = 1'b0;
      put(1'b0, 3'b010, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'h0);
      test_reset();
      test_rtype_add();
      test_encode_table();
      test_reject();
      test_back_to_back_full();
      test_reset_midflight();
      test_err_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
